// File: rtl/sd_defs.sv
// Shared definitions for the sigma-delta input unit: mode encodings, defaults
// and the Manchester mid-bit threshold helper.
package sd_defs;

    typedef enum logic [1:0] {
        SD_MODE_RISE  = 2'b00,
        SD_MODE_FALL  = 2'b01,
        SD_MODE_MANCH = 2'b10,
        SD_MODE_RSVD  = 2'b11
    } sd_mode_e;

    localparam int         SD_SYNC_STAGES_DEF = 2;
    localparam logic [7:0] SD_MANCH_CNT_MAX   = 8'hFF;

    // Edges later than 3/4 of a bit period after the last mid-bit edge are mid-bit edges.
    function automatic logic [7:0] manch_thresh(input logic [7:0] per);
        return 8'(({2'b00, per} + {1'b0, per, 1'b0}) >> 2);
    endfunction

endpackage

// File: rtl/sd_manch_dec.sv
// Manchester mid-bit recovery from the synchronised data pin.
// Only compiled when SD_MANCHESTER_EN is defined.
`ifdef SD_MANCHESTER_EN
module sd_manch_dec
    import sd_defs::*;
(
    input  logic       SYSCLK,
    input  logic       SYSRST,
    input  logic       dat_sync,
    input  logic [7:0] per,
    input  logic       en,
    output logic       strobe,
    output logic       dec_bit
);

    logic       dat_hist;
    logic [7:0] cnt;
    logic [7:0] thr;
    logic       edge_det;
    logic       take;

    assign thr      = manch_thresh(per);
    assign edge_det = dat_sync ^ dat_hist;
    assign take     = en && edge_det && (per >= 8'd4) && (cnt >= thr);

    // cnt is held saturated while idle so the first edge afterwards counts as mid-bit
    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            dat_hist <= 1'b0;
            cnt      <= SD_MANCH_CNT_MAX;
            strobe   <= 1'b0;
            dec_bit  <= 1'b0;
        end else begin
            dat_hist <= dat_sync;
            strobe   <= take;
            if (take)
                dec_bit <= dat_sync;
            if (!en)
                cnt <= SD_MANCH_CNT_MAX;
            else if (take)
                cnt <= 8'd0;
            else if (cnt != SD_MANCH_CNT_MAX)
                cnt <= cnt + 8'd1;
        end
    end

endmodule
`endif

// File: rtl/sd_input_unit.sv
// Sigma-delta channel front end: pin synchronisers, bit strobe recovery, clock-loss flag.
// Define SD_MANCHESTER_EN to enable Manchester decoding (mode 10) via sd_manch_dec.
module sd_input_unit
    import sd_defs::*;
#(
    parameter int SYNC_STAGES = SD_SYNC_STAGES_DEF,
    parameter int TMO_W       = 16
) (
    input  logic             SYSCLK,
    input  logic             SYSRST,
    input  logic             sd_clk_pin,
    input  logic             sd_d_pin,
    input  logic             in_en_reg,
    input  logic [1:0]       in_mode_reg,
    input  logic [7:0]       manch_per_reg,
    input  logic [TMO_W-1:0] clk_tmo_reg,
    input  logic             clk_fail_clr,
    output logic             sd_dsd_in,
    output logic             sd_clk_in,
    output logic             clk_fail
);

    sd_mode_e               mode;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_s;
    logic                   dat_s;
    logic                   clk_hist;
    logic                   rise_p0;
    logic                   fall_p0;
    logic                   dat_p0;
    logic                   m_stb_p0;
    logic                   m_bit_p0;
    logic                   manch_en;
    logic                   strobe_nxt;
    logic                   bit_nxt;
    logic [TMO_W-1:0]       tmo;
    logic [TMO_W-1:0]       tmo_nxt;

    assign mode     = sd_mode_e'(in_mode_reg);
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign dat_s    = dat_sync[SYNC_STAGES-1];
    assign manch_en = in_en_reg && (mode == SD_MODE_MANCH);

    // Synchronisers and edge detection; history always updates so enable/mode changes are glitch-free
    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            clk_sync <= '0;
            dat_sync <= '0;
            clk_hist <= 1'b0;
            rise_p0  <= 1'b0;
            fall_p0  <= 1'b0;
            dat_p0   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], sd_clk_pin};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], sd_d_pin};
            clk_hist <= clk_s;
            rise_p0  <= clk_s & ~clk_hist;
            fall_p0  <= ~clk_s & clk_hist;
            dat_p0   <= dat_s;
        end
    end

`ifdef SD_MANCHESTER_EN
    sd_manch_dec u_manch (
        .SYSCLK   (SYSCLK),
        .SYSRST   (SYSRST),
        .dat_sync (dat_s),
        .per      (manch_per_reg),
        .en       (manch_en),
        .strobe   (m_stb_p0),
        .dec_bit  (m_bit_p0)
    );
`else
    logic unused_manch;
    assign unused_manch = ^{manch_per_reg, manch_en};
    assign m_stb_p0     = 1'b0;
    assign m_bit_p0     = 1'b0;
`endif

    always_comb begin
        strobe_nxt = 1'b0;
        bit_nxt    = sd_dsd_in;
        if (in_en_reg) begin
            case (mode)
                SD_MODE_RISE: if (rise_p0) begin
                    strobe_nxt = 1'b1;
                    bit_nxt    = dat_p0;
                end
                SD_MODE_FALL: if (fall_p0) begin
                    strobe_nxt = 1'b1;
                    bit_nxt    = dat_p0;
                end
                SD_MODE_MANCH: if (m_stb_p0) begin
                    strobe_nxt = 1'b1;
                    bit_nxt    = m_bit_p0;
                end
                default: ;
            endcase
        end
    end

    assign tmo_nxt = (strobe_nxt || !in_en_reg) ? '0 :
                     (&tmo)                     ? tmo : tmo + TMO_W'(1);

    // Output registers and clock-loss detector; a set beats a coincident clear
    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            sd_clk_in <= 1'b0;
            sd_dsd_in <= 1'b0;
            tmo       <= '0;
            clk_fail  <= 1'b0;
        end else begin
            sd_clk_in <= strobe_nxt;
            sd_dsd_in <= bit_nxt;
            tmo       <= tmo_nxt;
            if ((clk_tmo_reg != '0) && (tmo_nxt == clk_tmo_reg))
                clk_fail <= 1'b1;
            else if (clk_fail_clr)
                clk_fail <= 1'b0;
        end
    end

endmodule
